// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
// Bit-serial, MSB-first magnitude comparator for WIDTH-bit operands.
// It supports unsigned and two's-complement compares, selected per operation,
// and stops at the first differing bit. A start/busy/done handshake lets a
// controller launch a compare and collect a registered gt/eq/lt result.

module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  // The index must reach WIDTH-1, so it needs at least one bit.
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] MSB_IDX  = IW'(WIDTH - 1);
  localparam logic [IW-1:0] ZERO_IDX = IW'(0);
  localparam logic [IW-1:0] ONE_IDX  = IW'(1);

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COMPARE = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             mode_q;
  logic [IW-1:0]    idx_q;

  logic             a_bit_s;
  logic             b_bit_s;
  logic             bits_differ_s;
  logic             at_sign_s;
  logic             at_lsb_s;
  logic [1:0]       decision_s;

  // Resolve a differing bit pair into {gt, lt}. At the sign position of a
  // signed compare the operand with the 1 bit is the negative one, so the
  // sense is swapped.
  function automatic logic [1:0] resolve_diff(
    input logic a_bit,
    input logic b_bit,
    input logic sign_pos
  );
    logic [1:0] res;
    if (sign_pos) begin
      res = {b_bit, a_bit};
    end else begin
      res = {a_bit, b_bit};
    end
    return res;
  endfunction

  // Decode the bit pair currently under examination.
  always_comb begin
    a_bit_s       = a_q[idx_q];
    b_bit_s       = b_q[idx_q];
    bits_differ_s = a_bit_s ^ b_bit_s;
    at_sign_s     = mode_q & (idx_q == MSB_IDX);
    at_lsb_s      = (idx_q == ZERO_IDX);
    decision_s    = resolve_diff(a_bit_s, b_bit_s, at_sign_s);
  end

  // Control FSM with operand capture, bit walk and registered result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      mode_q  <= 1'b0;
      idx_q   <= ZERO_IDX;
      busy    <= 1'b0;
      done    <= 1'b0;
      gt      <= 1'b0;
      eq      <= 1'b0;
      lt      <= 1'b0;
    end else begin
      // done is a single-cycle pulse; only the finishing edge raises it.
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            mode_q  <= signed_mode;
            idx_q   <= MSB_IDX;
            gt      <= 1'b0;
            eq      <= 1'b0;
            lt      <= 1'b0;
            busy    <= 1'b1;
            state_q <= COMPARE;
          end else begin
            state_q <= IDLE;
          end
        end
        COMPARE: begin
          if (bits_differ_s) begin
            // First differing bit decides the result.
            gt      <= decision_s[1];
            lt      <= decision_s[0];
            eq      <= 1'b0;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else if (at_lsb_s) begin
            // Every bit matched.
            gt      <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b1;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q   <= idx_q - ONE_IDX;
            state_q <= COMPARE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator. Three instances
// (WIDTH = 2, 8, 32) share operand buses; each has its own start line.

module tb_serial_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start2, start8, start32;
  logic        sm;
  logic [63:0] a_bus, b_bus;

  logic busy2, done2, gt2, eq2, lt2;
  logic busy8, done8, gt8, eq8, lt8;
  logic busy32, done32, gt32, eq32, lt32;

  int errors = 0;
  int checks = 0;
  int cycle = 0;
  int cap_cycle = 0;
  int sel = 1;

  logic o_busy, o_done, o_gt, o_eq, o_lt;

  typedef struct {
    int          s;
    logic [63:0] a;
    logic [63:0] b;
    logic        m;
    logic [2:0]  r;
    int          lat;
  } vec_t;

  serial_magnitude_comparator #(.WIDTH(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .signed_mode(sm),
    .a(a_bus[1:0]), .b(b_bus[1:0]),
    .busy(busy2), .done(done2), .gt(gt2), .eq(eq2), .lt(lt2));

  serial_magnitude_comparator #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .signed_mode(sm),
    .a(a_bus[7:0]), .b(b_bus[7:0]),
    .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8));

  serial_magnitude_comparator #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .signed_mode(sm),
    .a(a_bus[31:0]), .b(b_bus[31:0]),
    .busy(busy32), .done(done32), .gt(gt32), .eq(eq32), .lt(lt32));

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  always_comb begin
    case (sel)
      0:       {o_busy, o_done, o_gt, o_eq, o_lt} = {busy2, done2, gt2, eq2, lt2};
      1:       {o_busy, o_done, o_gt, o_eq, o_lt} = {busy8, done8, gt8, eq8, lt8};
      default: {o_busy, o_done, o_gt, o_eq, o_lt} = {busy32, done32, gt32, eq32, lt32};
    endcase
  end

  function automatic int w_of(input int s);
    return (s == 0) ? 2 : ((s == 1) ? 8 : 32);
  endfunction

  // Reference: arithmetic compare plus position of the highest differing bit.
  task automatic model(input int w, input logic [63:0] av, input logic [63:0] bv,
                       input logic m, output logic [2:0] r, output int lat);
    logic [63:0] mask, x, ua, ub;
    longint sa, sb;
    mask = (w == 64) ? ~64'd0 : ((64'd1 << w) - 64'd1);
    ua = av & mask;
    ub = bv & mask;
    x  = ua ^ ub;
    sa = $signed(ua << (64 - w)) >>> (64 - w);
    sb = $signed(ub << (64 - w)) >>> (64 - w);
    if (m) r = (sa > sb) ? 3'b100 : ((sa == sb) ? 3'b010 : 3'b001);
    else   r = (ua > ub) ? 3'b100 : ((ua == ub) ? 3'b010 : 3'b001);
    lat = (x == 64'd0) ? w : (w - ($clog2(x + 64'd1) - 1));
  endtask

  // Present a start for one edge (called at a falling edge).
  task automatic issue(input int s, input logic [63:0] av, input logic [63:0] bv,
                       input logic m);
    sel = s; a_bus = av; b_bus = bv; sm = m;
    start2 = (s == 0); start8 = (s == 1); start32 = (s == 2);
    cap_cycle = cycle + 1;
    @(negedge clk);
    start2 = 1'b0; start8 = 1'b0; start32 = 1'b0;
  endtask

  // Observe the selected instance until done; returns observations only.
  task automatic collect(input int w, output int lat, output logic [2:0] res,
                         output logic bsy, output bit to, output bit ph);
    to = 1'b1; ph = 1'b1; lat = 0; res = 3'b000; bsy = 1'b0;
    for (int i = 0; i < w + 3 && to; i++) begin
      if (o_done === 1'b1) begin
        to  = 1'b0;
        lat = cycle - cap_cycle;
        res = {o_gt, o_eq, o_lt};
        bsy = o_busy;
      end else begin
        if (o_busy !== 1'b1 || {o_gt, o_eq, o_lt} !== 3'b000) ph = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    issue(1, 64'h55, 64'h55, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy2, done2, gt2, eq2, lt2, busy8, done8, gt8, eq8, lt8,
         busy32, done32, gt32, eq32, lt32} !== 15'd0) begin
      errors++;
      $display("FAIL reset_async: outputs %b, required all zero",
               {busy8, done8, gt8, eq8, lt8});
    end
    @(negedge clk);
    checks++;
    if ({busy8, done8, gt8, eq8, lt8} !== 5'd0) begin
      errors++;
      $display("FAIL reset_held: got %b want 00000", {busy8, done8, gt8, eq8, lt8});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_unsigned();
    vec_t v [6];
    int lat; logic [2:0] res; logic bsy; bit to, ph;
    v = '{'{1, 64'hF0, 64'h0F, 1'b0, 3'b100, 1},
          '{1, 64'hA5, 64'hA5, 1'b0, 3'b010, 8},
          '{1, 64'h00, 64'h00, 1'b0, 3'b010, 8},
          '{1, 64'hFF, 64'hFF, 1'b0, 3'b010, 8},
          '{1, 64'h40, 64'h41, 1'b0, 3'b001, 8},
          '{1, 64'h80, 64'h7F, 1'b0, 3'b100, 1}};
    foreach (v[i]) begin
      issue(v[i].s, v[i].a, v[i].b, v[i].m);
      collect(w_of(v[i].s), lat, res, bsy, to, ph);
      checks++;
      if (to || lat != v[i].lat) begin
        errors++;
        $display("FAIL uns_latency case %0d: got %0d (timeout=%0d) want %0d", i, lat, to, v[i].lat);
      end
      checks++;
      if (res !== v[i].r) begin
        errors++;
        $display("FAIL uns_result case %0d: got %b want %b", i, res, v[i].r);
      end
      checks++;
      if (!ph || bsy !== 1'b0) begin
        errors++;
        $display("FAIL uns_busy case %0d: phase_ok=%0d busy_at_done=%b want 1/0", i, ph, bsy);
      end
      @(negedge clk);
      checks++;
      if ({o_done, o_busy, o_gt, o_eq, o_lt} !== {2'b00, v[i].r}) begin
        errors++;
        $display("FAIL uns_hold case %0d: got %b want %b", i,
                 {o_done, o_busy, o_gt, o_eq, o_lt}, {2'b00, v[i].r});
      end
    end
  endtask

  task automatic test_signed_and_widths();
    vec_t v [11];
    int lat; logic [2:0] res; logic bsy; bit to, ph;
    v = '{'{1, 64'h80, 64'h7F, 1'b1, 3'b001, 1},
          '{1, 64'hFE, 64'hFF, 1'b1, 3'b001, 8},
          '{0, 64'h2, 64'h1, 1'b0, 3'b100, 1},
          '{0, 64'h2, 64'h1, 1'b1, 3'b001, 1},
          '{0, 64'h3, 64'h3, 1'b1, 3'b010, 2},
          '{0, 64'h2, 64'h3, 1'b1, 3'b001, 2},
          '{2, 64'h80000000, 64'h7FFFFFFF, 1'b1, 3'b001, 1},
          '{2, 64'hDEADBEEF, 64'hDEADBEEF, 1'b0, 3'b010, 32},
          '{2, 64'h12345678, 64'h12345679, 1'b0, 3'b001, 32},
          '{2, 64'hFFFFFFFE, 64'hFFFFFFFF, 1'b1, 3'b001, 32},
          '{2, 64'h00010000, 64'h00000000, 1'b1, 3'b100, 16}};
    foreach (v[i]) begin
      issue(v[i].s, v[i].a, v[i].b, v[i].m);
      collect(w_of(v[i].s), lat, res, bsy, to, ph);
      checks++;
      if (to || lat != v[i].lat) begin
        errors++;
        $display("FAIL sgn_latency case %0d: got %0d (timeout=%0d) want %0d", i, lat, to, v[i].lat);
      end
      checks++;
      if (res !== v[i].r) begin
        errors++;
        $display("FAIL sgn_result case %0d: got %b want %b", i, res, v[i].r);
      end
      checks++;
      if (!ph || bsy !== 1'b0) begin
        errors++;
        $display("FAIL sgn_busy case %0d: phase_ok=%0d busy_at_done=%b want 1/0", i, ph, bsy);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy();
    int lat; logic [2:0] res; logic bsy; bit to, ph;
    issue(1, 64'hA5, 64'hA5, 1'b0);
    // Different operands and mode offered while busy must be ignored.
    a_bus = 64'h00; b_bus = 64'hFF; sm = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    a_bus = 64'hFF; b_bus = 64'h00; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    collect(8, lat, res, bsy, to, ph);
    checks++;
    if (to || lat != 8 || res !== 3'b010) begin
      errors++;
      $display("FAIL busy_ignore: got lat=%0d res=%b want lat=8 res=010", lat, res);
    end
    @(negedge clk);
    checks++;
    if ({o_busy, o_done, o_gt, o_eq, o_lt} !== 5'b00010) begin
      errors++;
      $display("FAIL busy_ignore_after: got %b want 00010", {o_busy, o_done, o_gt, o_eq, o_lt});
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [2:0] res; logic bsy; bit to, ph;
    issue(1, 64'h80, 64'h7F, 1'b1);
    collect(8, lat, res, bsy, to, ph);
    checks++;
    if (to || lat != 1 || res !== 3'b001) begin
      errors++;
      $display("FAIL b2b_first: got lat=%0d res=%b want lat=1 res=001", lat, res);
    end
    // Start in the done cycle.
    issue(1, 64'h40, 64'h41, 1'b0);
    checks++;
    if ({o_busy, o_done, o_gt, o_eq, o_lt} !== 5'b10000) begin
      errors++;
      $display("FAIL b2b_clear: got %b want 10000", {o_busy, o_done, o_gt, o_eq, o_lt});
    end
    collect(8, lat, res, bsy, to, ph);
    checks++;
    if (to || lat != 8 || res !== 3'b001 || !ph) begin
      errors++;
      $display("FAIL b2b_second: got lat=%0d res=%b ph=%0d want lat=8 res=001 ph=1", lat, res, ph);
    end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    int lat; logic [2:0] res; logic bsy; bit to, ph;
    int done_seen = 0;
    issue(1, 64'hA5, 64'hA5, 1'b0);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, gt8, eq8, lt8} !== 5'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got %b want 00000", {busy8, done8, gt8, eq8, lt8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done8 === 1'b1 || busy8 === 1'b1) done_seen++;
    end
    checks++;
    if (done_seen != 0) begin
      errors++;
      $display("FAIL midreset_nodone: got %0d active cycles want 0", done_seen);
    end
    issue(1, 64'hF0, 64'h0F, 1'b0);
    collect(8, lat, res, bsy, to, ph);
    checks++;
    if (to || lat != 1 || res !== 3'b100) begin
      errors++;
      $display("FAIL midreset_recover: got lat=%0d res=%b want lat=1 res=100", lat, res);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, elat, w, s, kind;
    logic [2:0] res, er; logic bsy; bit to, ph;
    logic [63:0] av, bv, mask;
    logic m;
    for (int i = 0; i < 1000; i++) begin
      s = i % 3;
      w = w_of(s);
      mask = (64'd1 << w) - 64'd1;
      av = {$urandom, $urandom} & mask;
      kind = $urandom_range(0, 3);
      if (kind == 0)      bv = av;
      else if (kind == 1) bv = av ^ (64'd1 << $urandom_range(0, w - 1));
      else                bv = {$urandom, $urandom} & mask;
      m = 1'($urandom_range(0, 1));
      model(w, av, bv, m, er, elat);
      issue(s, av, bv, m);
      collect(w, lat, res, bsy, to, ph);
      checks++;
      if (to || lat != elat) begin
        errors++;
        $display("FAIL rnd_latency W=%0d a=%h b=%h m=%0d: got %0d want %0d", w, av, bv, m, lat, elat);
      end
      checks++;
      if (res !== er) begin
        errors++;
        $display("FAIL rnd_result W=%0d a=%h b=%h m=%0d: got %b want %b", w, av, bv, m, res, er);
      end
      checks++;
      if (!ph || bsy !== 1'b0) begin
        errors++;
        $display("FAIL rnd_busy W=%0d: phase_ok=%0d busy_at_done=%b want 1/0", w, ph, bsy);
      end
    end
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; start2 = 1'b0; start8 = 1'b0; start32 = 1'b0;
    sm = 1'b0; a_bus = 64'd0; b_bus = 64'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_unsigned();
    test_signed_and_widths();
    test_start_while_busy();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

endmodule
